// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU with registered single-cycle ops and an iterative unsigned divider.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       signal,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] rem,
  output logic             zero,
  output logic             overflow,
  output logic             div0
);
  localparam logic [5:0] F_AND = 6'd36, F_OR = 6'd37, F_SUB = 6'd34, F_SLT = 6'd42, F_SRL = 6'd2, F_DIVU = 6'd27;
  localparam int M = WIDTH - 1;
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, DIV, OUT} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] divisor, sum, diff, res_c, q_nx, r_nx;
  logic [WIDTH:0] r_sh;
  logic [SHW-1:0] cnt;
  logic accept, is_div, last, ge, ovf_add, ovf_sub, ovf_c;
  always_comb begin
    in_ready = rst && (state == IDLE || (state == OUT && out_ready));
    out_valid = state == OUT;
    accept = in_valid && in_ready;
    is_div = signal == F_DIVU;
    sum = a + b;
    diff = a - b;
    ovf_add = (a[M] == b[M]) && (sum[M] != a[M]);
    ovf_sub = (a[M] != b[M]) && (diff[M] != a[M]);
    res_c = signal == F_AND ? a & b :
            signal == F_OR  ? a | b :
            signal == F_SUB ? diff :
            signal == F_SLT ? {{(WIDTH-1){1'b0}}, diff[M] ^ ovf_sub} :
            signal == F_SRL ? a >> shamt : sum;
    ovf_c = signal == F_SUB ? ovf_sub :
            (signal == F_AND || signal == F_OR || signal == F_SLT || signal == F_SRL) ? 1'b0 : ovf_add;
    // result/rem double as the quotient/partial-remainder shift pair while dividing
    r_sh = {rem, result[M]};
    ge = r_sh >= {1'b0, divisor};
    r_nx = ge ? r_sh[WIDTH-1:0] - divisor : r_sh[WIDTH-1:0];
    q_nx = {result[WIDTH-2:0], ge};
    last = cnt == LAST;
    state_nx = state;
    if (state == DIV) state_nx = last ? OUT : DIV;
    else if (accept) state_nx = (is_div && b != '0) ? DIV : OUT;
    else if (state == OUT && out_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result <= '0;
      rem <= '0;
      zero <= 1'b1;
      overflow <= 1'b0;
      div0 <= 1'b0;
      divisor <= '0;
      cnt <= '0;
    end else if (state == DIV) begin
      result <= q_nx;
      rem <= r_nx;
      cnt <= cnt + 1'b1;
      if (last) zero <= q_nx == '0;
    end else if (accept) begin
      overflow <= 1'b0;
      div0 <= 1'b0;
      if (is_div && b == '0) begin
        result <= '1;
        rem <= a;
        zero <= 1'b0;
        div0 <= 1'b1;
      end else if (is_div) begin
        result <= a;
        rem <= '0;
        divisor <= b;
        cnt <= '0;
      end else begin
        result <= res_c;
        rem <= '0;
        zero <= res_c == '0;
        overflow <= ovf_c;
      end
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed-vector bench for alu_multicycle; drives and samples on the falling edge.
module tb_alu_multicycle;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, zero, overflow, div0;
  logic [5:0] signal = 6'd0;
  logic [31:0] a = '0, b = '0, result, rem;
  logic [4:0] shamt = '0;
  int checks = 0, failures = 0;

  alu_multicycle #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .signal(signal),
    .a(a), .b(b), .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .rem(rem), .zero(zero), .overflow(overflow), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic single(input string tag, input logic [5:0] s, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic [4:0] sh, input logic [31:0] exp, input logic exp_ovf);
    in_valid = 1'b1; out_ready = 1'b1; signal = s; a = ta; b = tb_; shamt = sh;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, result, exp);
    check({tag, "_zero"}, 32'(zero), 32'(exp == 32'd0));
    check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, "_rem"}, rem, 32'd0);
  endtask

  task automatic run_div(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic [31:0] eq, input logic [31:0] er);
    int n, rdy;
    in_valid = 1'b1; out_ready = 1'b1; signal = 6'd27; a = ta; b = tb_;
    @(negedge clk);
    out_ready = 1'b0; signal = 6'd32; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    n = 1; rdy = int'(in_ready);
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
      rdy += int'(in_ready);
    end
    check({tag, "_latency"}, 32'(n), 32'd33);
    check({tag, "_in_ready_high"}, 32'(rdy), 32'd0);
    check({tag, "_quot"}, result, eq);
    check({tag, "_rem"}, rem, er);
    check({tag, "_zero"}, 32'(zero), 32'(eq == 32'd0));
    check({tag, "_div0"}, 32'(div0), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rem", rem, 32'd0);
    check("rst_flags", {29'd0, zero, overflow, div0}, 32'b100);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    single("add_ovf", 6'd32, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b1);
    single("sub_zero", 6'd34, 32'd5, 32'd5, 5'd0, 32'd0, 1'b0);
    single("slt_neg", 6'd42, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0);
    single("slt_pos", 6'd42, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b0);
    single("slt_ovf", 6'd42, 32'h8000_0000, 32'd1, 5'd0, 32'd1, 1'b0);
    single("srl_31", 6'd2, 32'h8000_0000, 32'd0, 5'd31, 32'd1, 1'b0);
    single("srl_0", 6'd2, 32'h8000_0000, 32'd0, 5'd0, 32'h8000_0000, 1'b0);
    single("and", 6'd36, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_F000, 1'b0);
    single("or", 6'd37, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_FFF0, 1'b0);
    single("sub_ovf", 6'd34, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF, 1'b1);
    single("add_neg_ovf", 6'd32, 32'h8000_0000, 32'h8000_0000, 5'd0, 32'd0, 1'b1);
    single("unknown_add", 6'd63, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("back_to_idle", 32'(out_valid), 32'd0);

    run_div("div_100_7", 32'd100, 32'd7, 32'd14, 32'd2);
    run_div("div_5_7", 32'd5, 32'd7, 32'd0, 32'd5);
    run_div("div_max_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    run_div("div_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0);

    in_valid = 1'b1; out_ready = 1'b0; signal = 6'd27; a = 32'd9; b = 32'd0;
    @(negedge clk);
    in_valid = 1'b0; a = 32'd77;
    for (int i = 0; i < 4; i++) begin
      check("div0_valid", 32'(out_valid), 32'd1);
      check("div0_result", result, 32'hFFFF_FFFF);
      check("div0_rem", rem, 32'd9);
      check("div0_flags", {29'd0, zero, overflow, div0}, 32'b001);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("div0_drain", 32'(out_valid), 32'd0);

    in_valid = 1'b1; out_ready = 1'b1; signal = 6'd27; a = 32'd100; b = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_div_valid", 32'(out_valid), 32'd0);
    check("rst_mid_div_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_mid_div_no_result", 32'(out_valid), 32'd0);
    single("add_after_rst", 6'd32, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0);

    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_in_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_out_zero", 32'(zero), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
